reg_pending_scoreboard: RTL

//  Register-hazard scoreboard for the ARMv4 core. Issue decodes a 4-bit destination

---
 rtl/reg_pending_scoreboard.sv | 96 +++++++++
 1 files changed

// File: rtl/reg_pending_scoreboard.sv
// rtl/reg_pending_scoreboard.sv - register-hazard scoreboard (pending-write mask and issue stall)
//
// Tracks outstanding register writes for R0-R15. Issue sets the destination's bit,
// writeback clears it, and source/destination lookups against the mask raise the stall.
//
// Optional feature macro: SCOREBOARD_BYPASS_EN
//   defined   - a same-cycle writeback masks its register out of the RAW/WAW checks
//   undefined - hazards are checked against the registered pending mask only
//
// Ports:
//   clk          in   1   core clock, rising edge
//   rst_n        in   1   asynchronous reset, active low
//   flush        in   1   pipeline flush; clears all pending bits
//   issue_valid  in   1   instruction presented with a destination register
//   issue_rd     in   4   destination register number
//   src_valid    in   3   per-source valid {Rs, Rm, Rn}
//   src_a        in   4   Rn register number
//   src_b        in   4   Rm register number
//   src_c        in   4   Rs register number
//   wb_valid     in   1   writeback this cycle
//   wb_rd        in   4   writeback register number
//   stall        out  1   combinational; issue blocked this cycle
//   issue_fire   out  1   combinational; issue_valid & ~stall & ~flush
//   pending      out  16  registered pending mask
//   busy         out  1   registered; |pending
//   wb_err       out  1   registered pulse; writeback to a non-pending register
module reg_pending_scoreboard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        issue_valid,
    input  logic [3:0]  issue_rd,
    input  logic [2:0]  src_valid,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    input  logic [3:0]  src_c,
    input  logic        wb_valid,
    input  logic [3:0]  wb_rd,
    output logic        stall,
    output logic        issue_fire,
    output logic [15:0] pending,
    output logic        busy,
    output logic        wb_err
);

    localparam int NREGS = 16;

    function automatic logic [NREGS-1:0] onehot(input logic [3:0] x);
        onehot = {{(NREGS-1){1'b0}}, 1'b1} << x;
    endfunction

    logic [NREGS-1:0] wb_clr;
    logic [NREGS-1:0] hz_mask;
    logic [NREGS-1:0] wbc;
    logic [NREGS-1:0] pending_next;
    logic             raw;
    logic             waw;

    always_comb begin
        wb_clr = '0;
`ifdef SCOREBOARD_BYPASS_EN
        // Forwarded writeback: the value is available this cycle, so no hazard.
        if (wb_valid)
            wb_clr = onehot(wb_rd);
`endif
        hz_mask = pending & ~wb_clr;

        raw = (src_valid[0] & hz_mask[src_a])
            | (src_valid[1] & hz_mask[src_b])
            | (src_valid[2] & hz_mask[src_c]);
        // A source equal to issue_rd only ever sees the old mask, never its own set.
        waw = hz_mask[issue_rd];

        stall      = issue_valid & (raw | waw);
        issue_fire = issue_valid & ~stall & ~flush;

        wbc = wb_valid ? onehot(wb_rd) : '0;
        // Set is OR-ed after the clear so a same-register issue wins over writeback.
        pending_next = (pending & ~wbc) | (issue_fire ? onehot(issue_rd) : '0);
        if (flush)
            pending_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            busy    <= 1'b0;
            wb_err  <= 1'b0;
        end else begin
            pending <= pending_next;
            busy    <= |pending_next;
            wb_err  <= wb_valid & ~pending[wb_rd] & ~flush;
        end
    end

endmodule
